// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage_pkg
// Brief   : Shared CPU constants: XLEN, write-back select and load encodings,
//           plus the MEM/WB pipeline-register record.
// Revision: 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

  localparam int XLEN = 32;

  // Write-back source select; the reserved code behaves like the ALU path.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    wb_sel_e         wb_sel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] mem_rdata;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage_if
// Brief   : MEM-stage inputs, pipeline controls and register-file write
//           outputs of the MEM/WB stage.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic            stall;
  logic            flush;
  logic            in_valid;
  logic            in_reg_write;
  logic [4:0]      in_rd;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_mem_rdata;
  logic            WE;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] instret;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, in_mem_rdata,
    input  WE, waddr, wdata, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, in_mem_rdata,
    output WE, waddr, wdata, instret
  );

endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Extracts and sign/zero-extends the loaded byte or halfword from an
//           aligned data-memory word.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lane, then extend according to the load type.
  always_comb begin
    sel_byte = word[7:0];
    case (offset)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    // Halfword lane depends only on offset[1]; a misaligned offset[0] is ignored.
    sel_half = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   value = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  value = {24'd0, sel_byte};
      F3_LH:   value = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  value = {16'd0, sel_half};
      default: value = word;  // LW and the unused codes return the whole word
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Brief   : MEM/WB pipeline register with register-file write-back selection
//           and a retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_wb_stage_if.slave bus
);

  wb_entry_t       entry_q;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] wdata_c;
  logic            we_c;

  // Pipeline register: flush wins over stall, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else if (bus.flush) begin
      entry_q <= '0;
    end else if (!bus.stall) begin
      entry_q.valid      <= bus.in_valid;
      entry_q.reg_write  <= bus.in_reg_write;
      entry_q.rd         <= bus.in_rd;
      entry_q.wb_sel     <= wb_sel_e'(bus.in_wb_sel);
      entry_q.funct3     <= bus.in_funct3;
      entry_q.alu_result <= bus.in_alu_result;
      entry_q.pc_plus4   <= bus.in_pc_plus4;
      entry_q.mem_rdata  <= bus.in_mem_rdata;
    end
  end

  // Count an instruction once, on the edge where it leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (entry_q.valid && !bus.stall) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  load_align u_load_align (
    .funct3 (entry_q.funct3),
    .offset (entry_q.alu_result[1:0]),
    .word   (entry_q.mem_rdata),
    .value  (load_value)
  );

  // Write-back port is purely a function of the stored entry.
  always_comb begin
    we_c    = entry_q.valid && entry_q.reg_write && (entry_q.rd != 5'd0);
    wdata_c = entry_q.alu_result;
    case (entry_q.wb_sel)
      WB_LOAD: wdata_c = load_value;
      WB_PC4:  wdata_c = entry_q.pc_plus4;
      default: wdata_c = entry_q.alu_result;
    endcase
  end

  assign bus.WE      = we_c;
  assign bus.waddr   = entry_q.rd;
  assign bus.wdata   = wdata_c;
  assign bus.instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Self-checking bench for mem_wb_stage with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the stored instruction and retire count.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_pc4, m_rdata, m_instret;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] v;
    int unsigned sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(off);
        v  = (word >> sh) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        sh = 16 * (int'(off) / 2);
        v  = (word >> sh) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata();
    if (m_sel == 2'd1) return ref_load(m_f3, m_alu[1:0], m_rdata);
    if (m_sel == 2'd2) return m_pc4;
    return m_alu;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_alu = 0; m_pc4 = 0; m_rdata = 0; m_instret = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".WE"},      {31'd0, bus.WE}, {31'd0, m_valid && m_rw && (m_rd != 5'd0)});
    chk({tag, ".waddr"},   {27'd0, bus.waddr}, {27'd0, m_rd});
    chk({tag, ".wdata"},   bus.wdata, ref_wdata());
    chk({tag, ".instret"}, bus.instret, m_instret);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] rdata,
                       input logic st, input logic fl);
    bus.in_valid = v;  bus.in_reg_write = rw; bus.in_rd = rd; bus.in_wb_sel = sel;
    bus.in_funct3 = f3; bus.in_alu_result = alu; bus.in_pc_plus4 = pc4;
    bus.in_mem_rdata = rdata; bus.stall = st; bus.flush = fl;
  endtask

  // One clock: update the model from the driven inputs, then check #1 later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (m_valid && !bus.stall) m_instret = m_instret + 32'd1;
    if (bus.flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
      m_alu = 0; m_pc4 = 0; m_rdata = 0;
    end else if (!bus.stall) begin
      m_valid = bus.in_valid; m_rw = bus.in_reg_write; m_rd = bus.in_rd;
      m_sel = bus.in_wb_sel; m_f3 = bus.in_funct3; m_alu = bus.in_alu_result;
      m_pc4 = bus.in_pc_plus4; m_rdata = bus.in_mem_rdata;
    end
    #1;
    chk_model(tag);
  endtask

  logic [31:0] saved;

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 chk_model("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU write-back, then idle to see the retire.
    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
    tick("alu");
    chk("alu.wdata_const", bus.wdata, 32'h1234_5678);
    chk("alu.WE_const", {31'd0, bus.WE}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("alu_retire");
    chk("alu.instret_const", bus.instret, 32'd1);

    // Load alignment cases.
    drive(1, 1, 5'd7, 2'b01, 3'b000, 32'h0000_1003, 0, 32'h80F0_7F01, 0, 0);
    tick("lb");  chk("lb.const", bus.wdata, 32'hFFFF_FF80);
    drive(1, 1, 5'd7, 2'b01, 3'b100, 32'h0000_1003, 0, 32'h80F0_7F01, 0, 0);
    tick("lbu"); chk("lbu.const", bus.wdata, 32'h0000_0080);
    drive(1, 1, 5'd7, 2'b01, 3'b001, 32'h0000_1002, 0, 32'h80F0_7F01, 0, 0);
    tick("lh");  chk("lh.const", bus.wdata, 32'hFFFF_80F0);
    drive(1, 1, 5'd7, 2'b01, 3'b101, 32'h0000_1001, 0, 32'h80F0_7F01, 0, 0);
    tick("lhu"); chk("lhu.const", bus.wdata, 32'h0000_7F01);
    drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_1003, 0, 32'h80F0_7F01, 0, 0);
    tick("lw");  chk("lw.const", bus.wdata, 32'h80F0_7F01);

    // Write to x0 is suppressed but still retires.
    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick("x0"); chk("x0.WE_const", {31'd0, bus.WE}, 32'd0);
    saved = bus.instret;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("x0_retire"); chk("x0.instret_inc", bus.instret, saved + 32'd1);

    // Stall for three cycles on a PC+4 write-back.
    drive(1, 1, 5'd1, 2'b10, 3'd0, 32'h0, 32'h0000_0104, 0, 0, 0);
    tick("link");
    saved = bus.instret;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd9, 2'b00, 3'd0, $urandom, $urandom, $urandom, 1, 0);
      tick("stall");
      chk("stall.WE_const", {31'd0, bus.WE}, 32'd1);
      chk("stall.wdata_const", bus.wdata, 32'h0000_0104);
      chk("stall.instret_hold", bus.instret, saved);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("stall_release");
    chk("stall.instret_once", bus.instret, saved + 32'd1);

    // Flush together with stall loads a bubble.
    drive(1, 1, 5'd3, 2'b00, 3'd0, 32'hAAAA_5555, 0, 0, 0, 0);
    tick("pre_flush");
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'h1111_2222, 0, 0, 1, 1);
    tick("flush_stall");
    chk("flush.WE_const", {31'd0, bus.WE}, 32'd0);

    // Asynchronous reset in the middle of a stall.
    drive(1, 1, 5'd6, 2'b00, 3'd0, 32'h0BAD_F00D, 0, 0, 0, 0);
    tick("pre_rst");
    drive(1, 1, 5'd6, 2'b00, 3'd0, 32'h0BAD_F00D, 0, 0, 1, 0);
    tick("rst_stall");
    #2 rst = 1'b1;
    #1;
    chk("arst.WE",      {31'd0, bus.WE}, 32'd0);
    chk("arst.waddr",   {27'd0, bus.waddr}, 32'd0);
    chk("arst.wdata",   bus.wdata, 32'd0);
    chk("arst.instret", bus.instret, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 5'd8, 2'b00, 3'd0, 32'hCAFE_0001, 0, 0, 0, 0);
    tick("post_rst_capture");

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      tick("rand");
    end

    // Counter wrap from the top of the range.
    drive(1, 0, 5'd2, 2'b00, 3'd0, 32'h0, 0, 0, 0, 0);
    tick("pre_wrap");
    force dut.instret_q = 32'hFFFF_FFFE;
    #1 release dut.instret_q;
    m_instret = 32'hFFFF_FFFE;
    tick("wrap1");
    chk("wrap.max", bus.instret, 32'hFFFF_FFFF);
    tick("wrap2");
    chk("wrap.zero", bus.instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  hold current contents.
REQ-004 SHALL have ports: flush  in  1  load a bubble.
REQ-005 SHALL have ports: in_valid  in  1  MEM-stage slot holds a real instruction.
REQ-006 SHALL have ports: in_reg_write  in  1  instruction writes rd.
REQ-007 SHALL have ports: in_rd  in  5  destination register.
REQ-008 SHALL have ports: in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
REQ-009 SHALL have ports: in_funct3  in  3  load size/sign.
REQ-010 SHALL have ports: in_alu_result  in  32  ALU result / load address.
REQ-011 SHALL have ports: in_pc_plus4  in  32  link value.
REQ-012 SHALL have ports: in_mem_rdata  in  32  raw aligned data-memory word.
REQ-013 SHALL have ports: WE  out  1  register-file write enable.
REQ-014 SHALL have ports: waddr  out  5  register-file write address.
REQ-015 SHALL have ports: wdata  out  32  register-file write data.
REQ-016 SHALL have ports: instret  out  32  retired-instruction counter.

Function
REQ-017 Pipeline register SHALL capture all in_* fields on a rising clk edge when stall=0 and flush=0.
REQ-018 Priority SHALL be rst > flush > stall > capture; flush with stall asserted SHALL still load a bubble (valid=0).
REQ-019 stall=1 (flush=0) SHALL hold every stored field unchanged.
REQ-020 WE, waddr, wdata SHALL be combinational from stored state only; one-cycle latency from capture, with the register-file write on the following edge.
REQ-021 WE SHALL equal stored valid AND stored reg_write AND (stored rd != 0); writes to x0 never occur.
REQ-022 waddr SHALL equal stored rd regardless of WE.
REQ-023 wdata SHALL be stored alu_result (sel 00/11), aligned load value (sel 01), or stored pc_plus4 (sel 10).
REQ-024 Load byte offset SHALL be stored alu_result[1:0].
REQ-025 LB (000) / LBU (100) SHALL select byte offset*8 and sign- or zero-extend it.
REQ-026 LH (001) / LHU (101) SHALL select the halfword addressed by offset[1], ignoring offset[0], and sign- or zero-extend it.
REQ-027 LW (010) and funct3 011/110/111 SHALL return the full word, ignoring offset.
REQ-028 instret SHALL increment by 1 on each rising edge where stored valid=1 and stall=0, regardless of reg_write.
REQ-029 instret SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 With stall=1 and a valid entry, WE SHALL remain asserted every cycle with identical waddr/wdata, and instret SHALL count that instruction only once.

Reset
REQ-031 On rst=1, asynchronously: stored valid=0, reg_write=0, rd=0, wb_sel=00, funct3=000, data fields=0, instret=0, giving outputs WE=0, waddr=0, wdata=0.
REQ-032 Reset mid-stall or mid-flush SHALL discard the held instruction; the first capture SHALL be on the first rising edge after rst deasserts.

Structure
REQ-033 wb_sel encodings, load funct3 encodings, and the 32-bit XLEN constant SHALL live in the shared CPU package.
REQ-034 Load alignment/extension SHALL be one combinational sub-module, load_align (inputs funct3, offset, word; output 32-bit value).

Verification
REQ-035 Bench SHALL cover: rd=5, reg_write=1, sel=00, alu=0x12345678 -> next cycle WE=1, waddr=5, wdata=0x12345678; instret +1.
REQ-036 Bench SHALL cover: mem_rdata=0x80F0_7F01, sel=01, alu[1:0]=3, LB -> wdata=0xFFFFFF80; LBU -> 0x00000080; LH offset 2 -> 0xFFFF80F0; LHU offset 1 -> 0x00007F01.
REQ-037 Bench SHALL cover: rd=0, reg_write=1 -> WE=0; instret still increments.
REQ-038 Bench SHALL cover: stall held 3 cycles on valid sel=10, pc_plus4=0x104 -> WE=1, wdata=0x104 all 3 cycles; instret +1 total after release.
REQ-039 Bench SHALL cover: flush and stall together -> bubble, WE=0 next cycle.
REQ-040 Bench SHALL cover: rst pulse mid-stall -> outputs 0 immediately, with no clock edge.
REQ-041 Bench SHALL cover: instret preset via 2^32-1 retirements (or forced) -> wraps to 0.
